// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: round-robin arbitration of two resolve ports into a small
// update FIFO, one BTB write per cycle, and a valid=0 sweep after reset or flush.
module btb_update_ctrl #(
  parameter int unsigned INDEX_W    = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [1:0]  upd_valid_i,
  output logic [1:0]  upd_ready_o,
  input  logic [59:0] upd_pc_i,
  input  logic [59:0] upd_bta_i,
  input  logic [3:0]  upd_br_type_i,
  output logic        btb_we_o,
  output logic [29:0] btb_wpc_o,
  output logic        btb_wvalid_o,
  output logic [29:0] btb_bta_o,
  output logic [1:0]  btb_br_type_o,
  output logic        busy_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AddrW = PtrW - 1;
  localparam int unsigned CntW  = INDEX_W + 1;

  typedef enum logic {StSweep, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, count;
  logic              rr_q;
  logic [29:0]       fifo_pc   [FIFO_DEPTH];
  logic [29:0]       fifo_bta  [FIFO_DEPTH];
  logic [1:0]        fifo_type [FIFO_DEPTH];

  logic              we_q, we_d, wvalid_q, wvalid_d;
  logic [29:0]       wpc_q, wpc_d, bta_q, bta_d;
  logic [1:0]        type_q, type_d;

  logic              empty, full, gp, accept, pop, push, merge, tail_live;
  logic [AddrW-1:0]  wr_idx, rd_idx, last_idx;
  logic [29:0]       in_pc, in_bta;
  logic [1:0]        in_type;

  assign wr_idx   = wr_ptr_q[AddrW-1:0];
  assign rd_idx   = rd_ptr_q[AddrW-1:0];
  assign last_idx = wr_idx - AddrW'(1);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_idx == rd_idx);

  // Arbitration, acceptance and duplicate-merge detection
  always_comb begin
    gp          = (upd_valid_i == 2'b11) ? rr_q : upd_valid_i[1];
    accept      = (|upd_valid_i) & ~flush_i & ~full;
    upd_ready_o = accept ? (gp ? 2'b10 : 2'b01) : 2'b00;
    in_pc       = gp ? upd_pc_i[59:30]     : upd_pc_i[29:0];
    in_bta      = gp ? upd_bta_i[59:30]    : upd_bta_i[29:0];
    in_type     = gp ? upd_br_type_i[3:2]  : upd_br_type_i[1:0];
    pop         = (state_q == StRun) & ~empty & ~flush_i;
    // The tail is leaving this cycle if it is the only entry being popped.
    tail_live   = ~empty & ~(pop & (count == PtrW'(1)));
    merge       = accept & tail_live & (fifo_pc[last_idx] == in_pc);
    push        = accept & ~merge;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StSweep;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_q     <= 1'b0;
      we_q     <= 1'b0;
      wvalid_q <= 1'b0;
      wpc_q    <= '0;
      bta_q    <= '0;
      type_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wvalid_q <= wvalid_d;
      wpc_q    <= wpc_d;
      bta_q    <= bta_d;
      type_q   <= type_d;
      if (accept) rr_q <= ~gp;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_pc[wr_idx]   <= in_pc;
      fifo_bta[wr_idx]  <= in_bta;
      fifo_type[wr_idx] <= in_type;
    end else if (rst_n && merge) begin
      fifo_bta[last_idx]  <= in_bta;
      fifo_type[last_idx] <= in_type;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = StSweep;
      cnt_d   = '0;
    end else if (state_q == StSweep) begin
      cnt_d = cnt_q + CntW'(1);
      if (&cnt_q) state_d = StRun;
    end
  end

  // Next BTB write: sweep slot, popped entry, or idle with fields held
  always_comb begin
    we_d     = 1'b0;
    wvalid_d = wvalid_q;
    wpc_d    = wpc_q;
    bta_d    = bta_q;
    type_d   = type_q;
    if (!flush_i) begin
      if (state_q == StSweep) begin
        we_d     = 1'b1;
        wvalid_d = 1'b0;
        wpc_d    = 30'(cnt_q);
        bta_d    = '0;
        type_d   = '0;
      end else if (pop) begin
        we_d     = 1'b1;
        wvalid_d = 1'b1;
        wpc_d    = fifo_pc[rd_idx];
        bta_d    = fifo_bta[rd_idx];
        type_d   = fifo_type[rd_idx];
      end
    end
  end

  assign btb_we_o      = we_q;
  assign btb_wvalid_o  = wvalid_q;
  assign btb_wpc_o     = wpc_q;
  assign btb_bta_o     = bta_q;
  assign btb_br_type_o = type_q;
  assign busy_o        = (state_q == StSweep);

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl with INDEX_W=3 (16-slot sweep) and FIFO_DEPTH=4.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  upd_valid;
  logic [1:0]  upd_ready;
  logic [59:0] upd_pc;
  logic [59:0] upd_bta;
  logic [3:0]  upd_type;
  logic        we, wvalid, busy;
  logic [29:0] wpc, bta;
  logic [1:0]  br_type;

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr;

  btb_update_ctrl #(
    .INDEX_W   (3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .upd_valid_i  (upd_valid),
    .upd_ready_o  (upd_ready),
    .upd_pc_i     (upd_pc),
    .upd_bta_i    (upd_bta),
    .upd_br_type_i(upd_type),
    .btb_we_o     (we),
    .btb_wpc_o    (wpc),
    .btb_wvalid_o (wvalid),
    .btb_bta_o    (bta),
    .btb_br_type_o(br_type),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [29:0] pc, input logic [29:0] t,
                          input logic [1:0] ty);
    if (p == 0) begin
      upd_pc[29:0] = pc; upd_bta[29:0] = t; upd_type[1:0] = ty;
    end else begin
      upd_pc[59:30] = pc; upd_bta[59:30] = t; upd_type[3:2] = ty;
    end
  endtask

  task automatic wait_sweep_done();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("sweep_end", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_we", {63'd0, we}, 64'd0);
    chk("flush_busy", {63'd0, busy}, 64'd1);
  endtask

  function automatic logic [29:0] exp_pc3(input int j);
    return (j % 2 == 0) ? 30'(32'h300 + j) : 30'(32'h400 + j);
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; upd_valid = 2'b00;
    upd_pc = '0; upd_bta = '0; upd_type = '0;
    tick(); tick();
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
    chk("rst_wpc", {34'd0, wpc}, 64'd0);
    chk("rst_bta", {34'd0, bta}, 64'd0);
    chk("rst_type", {62'd0, br_type}, 64'd0);
    chk("rst_ready", {62'd0, upd_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);

    // Reset sweep: 16 invalidating writes, busy falls with the last one
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("sweep_we", {63'd0, we}, 64'd1);
      chk("sweep_wvalid", {63'd0, wvalid}, 64'd0);
      chk("sweep_wpc", {34'd0, wpc}, 64'(i));
      chk("sweep_busy", {63'd0, busy}, (i == 15) ? 64'd0 : 64'd1);
    end
    tick();
    chk("idle_we", {63'd0, we}, 64'd0);

    // Single request on port 0
    set_port(0, 30'h100, 30'h200, 2'd2);
    upd_valid = 2'b01;
    #1 chk("p0_ready", {62'd0, upd_ready}, 64'd1);
    tick();
    upd_valid = 2'b00;
    chk("p0_latency_we", {63'd0, we}, 64'd0);
    tick();
    chk("p0_we", {63'd0, we}, 64'd1);
    chk("p0_wvalid", {63'd0, wvalid}, 64'd1);
    chk("p0_wpc", {34'd0, wpc}, 64'h100);
    chk("p0_bta", {34'd0, bta}, 64'h200);
    chk("p0_type", {62'd0, br_type}, 64'd2);
    tick();
    chk("p0_after_we", {63'd0, we}, 64'd0);
    chk("p0_hold_wpc", {34'd0, wpc}, 64'h100);

    // Round-robin with both ports valid, starting from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_sweep_done();
    tick();
    for (int i = 0; i < 4; i++) begin
      set_port(0, 30'(32'h300 + i), 30'(32'h1300 + i), 2'(i));
      set_port(1, 30'(32'h400 + i), 30'(32'h1400 + i), 2'(i));
      upd_valid = 2'b11;
      #1 chk("rr_ready", {62'd0, upd_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      if (i > 0) begin
        chk("rr_we", {63'd0, we}, 64'd1);
        chk("rr_wpc", {34'd0, wpc}, {34'd0, exp_pc3(i - 1)});
      end
    end
    upd_valid = 2'b00;
    tick();
    chk("rr_we_last", {63'd0, we}, 64'd1);
    chk("rr_wpc_last", {34'd0, wpc}, {34'd0, exp_pc3(3)});
    chk("rr_bta_last", {34'd0, bta}, 64'h1403);
    tick();

    // Fill the FIFO during a sweep: fifth request refused, four drain afterwards
    do_flush();
    for (int i = 0; i < 5; i++) begin
      set_port(0, 30'(32'h500 + i), 30'(32'h700 + i), 2'd1);
      upd_valid = 2'b01;
      #1 chk("full_ready", {62'd0, upd_ready}, (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    upd_valid = 2'b00;
    wait_sweep_done();
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (we && wvalid) begin
        chk("full_drain_wpc", {34'd0, wpc}, 64'(32'h500 + n_wr));
        n_wr++;
      end
    end
    chk("full_drain_count", 64'(n_wr), 64'd4);

    // Flush mid-sweep at cnt=7 with two entries queued
    do_flush();
    for (int i = 0; i < 2; i++) begin
      set_port(0, 30'(32'h600 + i), 30'h123, 2'd3);
      upd_valid = 2'b01;
      tick();
    end
    upd_valid = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_flush_wpc", {34'd0, wpc}, 64'd6);
    set_port(0, 30'h6ff, 30'h1, 2'd1);
    upd_valid = 2'b01;
    flush = 1'b1;
    #1 chk("flush_ready", {62'd0, upd_ready}, 64'd0);
    tick();
    flush = 1'b0;
    upd_valid = 2'b00;
    chk("mid_flush_we", {63'd0, we}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("resweep_we", {63'd0, we}, 64'd1);
      chk("resweep_wvalid", {63'd0, wvalid}, 64'd0);
      chk("resweep_wpc", {34'd0, wpc}, 64'(i));
    end
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (we) n_wr++;
    end
    chk("flushed_entries_writes", 64'(n_wr), 64'd0);

    // Same pc twice before any pop merges into one write with the newer target
    do_flush();
    set_port(0, 30'h40, 30'h80, 2'd2);
    upd_valid = 2'b01;
    tick();
    set_port(0, 30'h40, 30'h90, 2'd1);
    #1 chk("merge_ready", {62'd0, upd_ready}, 64'd1);
    tick();
    upd_valid = 2'b00;
    wait_sweep_done();
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (we && wvalid) begin
        n_wr++;
        chk("merge_wpc", {34'd0, wpc}, 64'h40);
        chk("merge_bta", {34'd0, bta}, 64'h90);
        chk("merge_type", {62'd0, br_type}, 64'd1);
      end
    end
    chk("merge_count", 64'(n_wr), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
